// File: rtl/count_pwm_compare_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count_pwm_compare_pkg
// Description : Shared types, constants and the duty saturation helper for
//               the counter-compare PWM block and its edge sampler.
// Revision    : 1.0 - initial release
// ============================================================================
package count_pwm_compare_pkg;

    // Default counter width; the period is 2^CNT_N counts
    localparam int CNT_N  = 4;
    localparam int PERIOD = 2 ** CNT_N;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Clamp a requested duty to the full period 2^n (100 %)
    function automatic logic [31:0] sat_duty(input int unsigned n, input logic [31:0] value);
        logic [31:0] full;
        full = 32'd1 << n;
        if (value > full) begin
            return full;
        end
        return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/count_sample_edge.sv
`default_nettype none
// ============================================================================
// Module      : count_sample_edge
// Description : Two-stage capture of an upstream up-counter value with wrap
//               and value-change detection. Reusable by any counter consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module count_sample_edge #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] cnt_in,
    output logic [N-1:0] cnt_q,
    output logic         wrap_det,
    output logic         new_val
);

    logic [N-1:0] r_cnt_q;
    logic [N-1:0] r_cnt_d;

    // Capture the counter and keep the previous sample for edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt_q <= '0;
            r_cnt_d <= '0;
        end else begin
            r_cnt_q <= cnt_in;
            r_cnt_d <= r_cnt_q;
        end
    end

    // Any decrease is a roll-over, including rolls that skip values
    assign wrap_det = (r_cnt_q < r_cnt_d);
    assign new_val  = (r_cnt_q != r_cnt_d);
    assign cnt_q    = r_cnt_q;

endmodule
`default_nettype wire

// File: rtl/count_pwm_compare.sv
`default_nettype none
// ============================================================================
// Module      : count_pwm_compare
// Description : PWM generator driven by a free-running N-bit counter. Duty is
//               shadowed and transferred on counter wrap; emits registered
//               wrap and compare-match event pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module count_pwm_compare
    import count_pwm_compare_pkg::*;
#(
    parameter int N      = CNT_N,
    parameter int DUTY_W = N + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [N-1:0]      cnt_in,
    input  logic              enable,
    input  logic [DUTY_W-1:0] duty_in,
    input  logic              duty_wr,
    output logic              pwm_out,
    output logic              wrap_pulse,
    output logic              match_pulse,
    output logic              duty_pending,
    output logic              running
);

    logic [N-1:0]      w_cnt_q;
    logic              w_wrap_det;
    logic              w_new_val;
    logic [DUTY_W-1:0] w_cnt_ext;

    state_t            r_state;
    state_t            w_state_next;

    logic [DUTY_W-1:0] r_duty_act;
    logic [DUTY_W-1:0] r_duty_pend;
    logic              r_duty_pending;
    logic [DUTY_W-1:0] w_duty_sat;
    logic [DUTY_W-1:0] w_duty_eff;
    logic              w_pending_next;

    logic              r_pwm;
    logic              r_wrap;
    logic              r_match;
    logic              w_pwm_next;
    logic              w_wrap_next;
    logic              w_match_next;

    count_sample_edge #(
        .N (N)
    ) u_sample (
        .clk      (clk),
        .rstn     (rstn),
        .cnt_in   (cnt_in),
        .cnt_q    (w_cnt_q),
        .wrap_det (w_wrap_det),
        .new_val  (w_new_val)
    );

    assign w_cnt_ext  = DUTY_W'(w_cnt_q);
    assign w_duty_sat = DUTY_W'(sat_duty(N, 32'(duty_in)));

    // Duty after any transfer at this wrap; a coincident write bypasses the shadow
    always_comb begin
        w_duty_eff     = r_duty_act;
        w_pending_next = r_duty_pending;
        if (w_wrap_det) begin
            if (duty_wr) begin
                w_duty_eff = w_duty_sat;
            end else if (r_duty_pending) begin
                w_duty_eff = r_duty_pend;
            end
            w_pending_next = 1'b0;
        end else if (duty_wr) begin
            w_pending_next = 1'b1;
        end
    end

    // Shadow and active duty registers; transfers happen in every state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_duty_act     <= '0;
            r_duty_pend    <= '0;
            r_duty_pending <= 1'b0;
        end else begin
            r_duty_act     <= w_duty_eff;
            r_duty_pending <= w_pending_next;
            if (duty_wr) begin
                r_duty_pend <= w_duty_sat;
            end
        end
    end

    // Next state: arm on enable, run from a wrap so the first period is full
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (enable) w_state_next = ARM;
            ARM:     if (w_wrap_det) w_state_next = RUN;
            RUN:     w_state_next = RUN;
            default: w_state_next = IDLE;
        endcase
        if (!enable) begin
            w_state_next = IDLE;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Output decode against the post-transfer duty; zero duty never matches
    always_comb begin
        w_pwm_next   = 1'b0;
        w_match_next = 1'b0;
        w_wrap_next  = w_wrap_det && enable && (r_state != IDLE);
        if (w_state_next == RUN) begin
            w_pwm_next   = (w_cnt_ext < w_duty_eff);
            w_match_next = w_new_val && (w_cnt_ext == w_duty_eff) && (w_duty_eff != '0);
        end
    end

    // Registered event and waveform outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pwm   <= 1'b0;
            r_wrap  <= 1'b0;
            r_match <= 1'b0;
        end else begin
            r_pwm   <= w_pwm_next;
            r_wrap  <= w_wrap_next;
            r_match <= w_match_next;
        end
    end

    assign pwm_out      = r_pwm;
    assign wrap_pulse   = r_wrap;
    assign match_pulse  = r_match;
    assign duty_pending = r_duty_pending;
    assign running      = (r_state == RUN);

endmodule
`default_nettype wire

// File: tb/tb_count_pwm_compare.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_pwm_compare
// Description : Scoreboard bench for count_pwm_compare (N=4, DUTY_W=5).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_pwm_compare;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] cnt_in;
    logic       enable;
    logic [4:0] duty_in;
    logic       duty_wr;
    logic       pwm_out;
    logic       wrap_pulse;
    logic       match_pulse;
    logic       duty_pending;
    logic       running;

    typedef struct packed {
        logic pwm;
        logic wrap;
        logic match;
        logic pending;
        logic run;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [3:0] m_p1      = '0;
    logic [3:0] m_p2      = '0;
    int         m_st      = 0;
    logic [4:0] m_act     = '0;
    logic [4:0] m_pend    = '0;
    logic       m_pending = 1'b0;

    logic [3:0] tb_cnt = '0;
    int hi_cnt, match_cnt, wrap_cnt;

    count_pwm_compare #(
        .N      (4),
        .DUTY_W (5)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .cnt_in       (cnt_in),
        .enable       (enable),
        .duty_in      (duty_in),
        .duty_wr      (duty_wr),
        .pwm_out      (pwm_out),
        .wrap_pulse   (wrap_pulse),
        .match_pulse  (match_pulse),
        .duty_pending (duty_pending),
        .running      (running)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_p1 = '0; m_p2 = '0; m_st = 0;
        m_act = '0; m_pend = '0; m_pending = 1'b0;
    endtask

    task automatic clear_stats();
        hi_cnt = 0; match_cnt = 0; wrap_cnt = 0;
    endtask

    // Drive one cycle of stimulus at the negedge, predict, then score after the edge
    task automatic step(input logic [3:0] cnt, input logic en, input logic wr, input logic [4:0] din);
        exp_t       e;
        exp_t       got;
        logic       wrap, newv;
        logic [4:0] sat, eff;
        int         nst;
        cnt_in = cnt; enable = en; duty_wr = wr; duty_in = din;
        wrap = (m_p1 < m_p2);
        newv = (m_p1 != m_p2);
        sat  = (din > 5'd16) ? 5'd16 : din;
        eff  = m_act;
        if (wrap) begin
            if (wr) eff = sat;
            else if (m_pending) eff = m_pend;
        end
        nst = m_st;
        if (m_st == 0 && en) nst = 1;
        else if (m_st == 1 && wrap) nst = 2;
        if (!en) nst = 0;
        e.pwm     = (nst == 2) && ({1'b0, m_p1} < eff);
        e.match   = (nst == 2) && newv && ({1'b0, m_p1} == eff) && (eff != 5'd0);
        e.wrap    = wrap && en && (m_st != 0);
        e.pending = wr ? !wrap : (wrap ? 1'b0 : m_pending);
        e.run     = (nst == 2);
        m_act = eff;
        if (wr) m_pend = sat;
        m_pending = e.pending;
        m_st = nst;
        m_p2 = m_p1;
        m_p1 = cnt;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        got = '{pwm: pwm_out, wrap: wrap_pulse, match: match_pulse, pending: duty_pending, run: running};
        check("pwm_out", 32'(got.pwm), 32'(e.pwm));
        check("wrap_pulse", 32'(got.wrap), 32'(e.wrap));
        check("match_pulse", 32'(got.match), 32'(e.match));
        check("duty_pending", 32'(got.pending), 32'(e.pending));
        check("running", 32'(got.run), 32'(e.run));
        hi_cnt    += int'(pwm_out);
        match_cnt += int'(match_pulse);
        wrap_cnt  += int'(wrap_pulse);
    endtask

    task automatic run(input int n, input logic en);
        for (int i = 0; i < n; i++) begin
            step(tb_cnt, en, 1'b0, 5'd0);
            tb_cnt++;
        end
    endtask

    task automatic run_to(input logic [3:0] c);
        do begin
            run(1, 1'b1);
        end while (tb_cnt != c);
    endtask

    task automatic write(input logic [4:0] d);
        step(tb_cnt, 1'b1, 1'b1, d);
        tb_cnt++;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_pwm"}, 32'(pwm_out), 0);
        check({tag, "_wrap"}, 32'(wrap_pulse), 0);
        check({tag, "_match"}, 32'(match_pulse), 0);
        check({tag, "_pending"}, 32'(duty_pending), 0);
        check({tag, "_running"}, 32'(running), 0);
    endtask

    task automatic period_stats(input string tag, input int exp_hi, input int exp_match);
        clear_stats();
        run(16, 1'b1);
        check({tag, "_hi_count"}, 32'(hi_cnt), 32'(exp_hi));
        check({tag, "_match_count"}, 32'(match_cnt), 32'(exp_match));
        check({tag, "_wrap_count"}, 32'(wrap_cnt), 1);
    endtask

    initial begin
        logic [4:0] bd_duty [3];
        int         bd_hi   [3];
        bd_duty = '{5'd0, 5'd16, 5'd31};
        bd_hi   = '{0, 16, 16};

        rstn = 1'b0; cnt_in = '0; enable = 1'b0; duty_in = '0; duty_wr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        rstn = 1'b1;

        // Duty 5, free-running counter
        write(5'd5);
        run(20, 1'b1);
        period_stats("duty5", 5, 1);

        // Shadowed update to 12 written mid-period
        while (tb_cnt != 4'd7) run(1, 1'b1);
        write(5'd12);
        check("pending_after_write", 32'(duty_pending), 1);
        run_to(4'd0);
        run(4, 1'b1);
        period_stats("duty12", 12, 1);

        // Write coinciding with the wrap cycle bypasses the shadow
        run_to(4'd1);
        write(5'd10);
        check("pending_on_wrap_write", 32'(duty_pending), 0);
        run(2, 1'b1);
        period_stats("duty10", 10, 1);

        // Boundary duties
        for (int k = 0; k < 3; k++) begin
            write(bd_duty[k]);
            run_to(4'd0);
            run_to(4'd4);
            period_stats($sformatf("bound%0d", bd_duty[k]), bd_hi[k], 0);
        end

        // Disable while high, then a stalled counter
        write(5'd12);
        run_to(4'd0);
        run_to(4'd3);
        step(tb_cnt, 1'b0, 1'b0, 5'd0);
        check("disable_pwm", 32'(pwm_out), 0);
        check("disable_running", 32'(running), 0);
        clear_stats();
        for (int i = 0; i < 20; i++) step(4'd9, 1'b0, 1'b0, 5'd0);
        check("stall_idle_wrap", 32'(wrap_cnt), 0);
        check("stall_idle_match", 32'(match_cnt), 0);
        tb_cnt = 4'd10;
        run_to(4'd0);
        run_to(4'd0);
        run_to(4'd5);
        for (int i = 0; i < 3; i++) step(4'd9, 1'b1, 1'b0, 5'd0);
        clear_stats();
        for (int i = 0; i < 17; i++) step(4'd9, 1'b1, 1'b0, 5'd0);
        check("stall_run_hi", 32'(hi_cnt), 17);
        check("stall_run_match", 32'(match_cnt), 0);
        check("stall_run_wrap", 32'(wrap_cnt), 0);

        // Asynchronous reset in RUN at duty 8
        tb_cnt = 4'd10;
        write(5'd8);
        run_to(4'd0);
        run_to(4'd0);
        run_to(4'd6);
        check("pre_reset_running", 32'(running), 1);
        check("pre_reset_pwm", 32'(pwm_out), 1);
        #2 rstn = 1'b0;
        #1 check_outputs_zero("async_reset");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            cnt_in = tb_cnt;
            tb_cnt++;
        end
        @(negedge clk);
        model_reset();
        rstn = 1'b1;
        run_to(4'd15);
        check("restart_running_before_wrap", 32'(running), 0);
        run(2, 1'b1);
        check("restart_running_at_zero", 32'(running), 0);
        run(1, 1'b1);
        check("restart_running_after_wrap", 32'(running), 1);
        run(4, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
